// File: rtl/banner_editor.sv
`default_nettype none
// ============================================================================
//  Module   : banner_editor
//  Purpose  : Three-button editor for a ten-digit BCD banner. Buttons are
//             synchronized and debounced. Their rising edges move a cursor
//             or increment/decrement the digit under it. The cursor digit
//             blinks through a registered blank mask while editing.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous active-high reset
//             edit_en    - level enable for editing
//             btn_next   - raw pushbutton, advance cursor
//             btn_inc    - raw pushbutton, increment digit at cursor
//             btn_dec    - raw pushbutton, decrement digit at cursor
//             banner     - ten BCD digits, digit k at [4k+3:4k]
//             cursor     - index 0..9 of the digit being edited
//             blank_mask - bit k high blanks digit k on the display
//             changed    - one-cycle pulse when banner takes a new value
//  Revision : 1.0 - initial release
// ============================================================================
module banner_editor #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        edit_en,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    output logic [39:0] banner,
    output logic [3:0]  cursor,
    output logic [9:0]  blank_mask,
    output logic        changed
);

    localparam int             c_DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int             c_BL_W      = $clog2(BLINK_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_BL_W-1:0] c_BL_LAST = c_BL_W'(BLINK_CYCLES - 1);
    localparam logic [39:0]    c_BANNER_RST = 40'h0987654321;

    // Button index: 0 = next, 1 = inc, 2 = dec
    logic [2:0] w_raw;
    logic [2:0] w_press;

    assign w_raw = {btn_dec, btn_inc, btn_next};

    // ------------------------------------------------------------------------
    // Per-button synchronizer, debouncer and press-edge detector
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic              r_s1;
        logic              r_s2;
        logic              r_deb;
        logic              r_deb_d;
        logic              r_armed;
        logic [1:0]        r_vld;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_armed <= 1'b0;
                r_vld   <= 2'b00;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_raw[g];
                r_s2    <= r_s1;
                r_deb_d <= r_deb;
                // r_vld marks when r_s2 holds a real post-reset sample.
                // A button is armed only once it has been seen released,
                // so one held through reset cannot fire a press.
                r_vld   <= {r_vld[0], 1'b1};
                if (r_vld[1] && !r_s2) begin
                    r_armed <= 1'b1;
                end
                // Count consecutive cycles the synchronized level disagrees
                // with the accepted level; any agreement restarts the count.
                if (r_s2 != r_deb) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[g] = r_deb & ~r_deb_d & r_armed;
    end

    // ------------------------------------------------------------------------
    // Edit datapath
    // ------------------------------------------------------------------------
    logic [39:0]       r_banner;
    logic [3:0]        r_cursor;
    logic [9:0]        r_blank;
    logic              r_changed;
    logic [c_BL_W-1:0] r_blink_cnt;
    logic              r_blink_phase;

    logic              w_next;
    logic              w_inc;
    logic              w_dec;
    logic [3:0]        w_old_digit;
    logic [3:0]        w_new_digit;
    logic              w_digit_edit;
    logic [39:0]       w_banner_next;
    logic [3:0]        w_cursor_next;
    logic [c_BL_W-1:0] w_blink_cnt_next;
    logic              w_blink_phase_next;
    logic [9:0]        w_blank_next;

    // Presses are dropped while editing is disabled; debouncers keep running.
    assign w_next = w_press[0] & edit_en;
    assign w_inc  = w_press[1] & edit_en;
    assign w_dec  = w_press[2] & edit_en;

    always_comb begin
        w_old_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_cursor == 4'(k)) begin
                w_old_digit = r_banner[4*k +: 4];
            end
        end

        // Simultaneous inc and dec cancel. Out-of-range digits are folded
        // back into 0..9 so the banner can never hold a non-BCD value.
        w_new_digit  = w_old_digit;
        w_digit_edit = 1'b0;
        if (w_inc && !w_dec) begin
            w_digit_edit = 1'b1;
            w_new_digit  = (w_old_digit >= 4'd9) ? 4'd0 : w_old_digit + 4'd1;
        end else if (w_dec && !w_inc) begin
            w_digit_edit = 1'b1;
            w_new_digit  = (w_old_digit == 4'd0 || w_old_digit > 4'd9) ?
                           4'd9 : w_old_digit - 4'd1;
        end

        // Edit applies at the old cursor even if next fires in this cycle.
        w_banner_next = r_banner;
        for (int k = 0; k < 10; k++) begin
            if (w_digit_edit && (r_cursor == 4'(k))) begin
                w_banner_next[4*k +: 4] = w_new_digit;
            end
        end

        w_cursor_next = r_cursor;
        if (w_next) begin
            w_cursor_next = (r_cursor >= 4'd9) ? 4'd0 : r_cursor + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Cursor blink
    // ------------------------------------------------------------------------
    always_comb begin
        w_blink_cnt_next   = r_blink_cnt;
        w_blink_phase_next = r_blink_phase;
        if (!edit_en) begin
            w_blink_cnt_next   = '0;
            w_blink_phase_next = 1'b1;
        end else if (r_blink_cnt == c_BL_LAST) begin
            w_blink_cnt_next   = '0;
            w_blink_phase_next = ~r_blink_phase;
        end else begin
            w_blink_cnt_next   = r_blink_cnt + 1'b1;
        end

        // Built from next-state values so the registered mask lines up with
        // the cursor and phase registers updated on the same edge.
        if (edit_en && !w_blink_phase_next) begin
            w_blank_next = 10'd1 << w_cursor_next;
        end else begin
            w_blank_next = 10'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_banner      <= c_BANNER_RST;
            r_cursor      <= 4'd0;
            r_blank       <= 10'd0;
            r_changed     <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else begin
            r_banner      <= w_banner_next;
            r_cursor      <= w_cursor_next;
            r_blank       <= w_blank_next;
            r_changed     <= w_digit_edit;
            r_blink_cnt   <= w_blink_cnt_next;
            r_blink_phase <= w_blink_phase_next;
        end
    end

    assign banner     = r_banner;
    assign cursor     = r_cursor;
    assign blank_mask = r_blank;
    assign changed    = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_banner_editor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_banner_editor
//  Purpose  : Directed self-checking bench for banner_editor with
//             DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_banner_editor;

    logic        clk;
    logic        rst;
    logic        edit_en;
    logic        btn_next;
    logic        btn_inc;
    logic        btn_dec;
    logic [39:0] banner;
    logic [3:0]  cursor;
    logic [9:0]  blank_mask;
    logic        changed;

    int errors;
    int checks;

    banner_editor #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .edit_en   (edit_en),
        .btn_next  (btn_next),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .banner    (banner),
        .cursor    (cursor),
        .blank_mask(blank_mask),
        .changed   (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold the chosen buttons for 10 edges, release for 12, count changed pulses.
    task automatic press(input logic n, input logic i, input logic d, output int chg);
        chg      = 0;
        btn_next = n;
        btn_inc  = i;
        btn_dec  = d;
        repeat (10) begin
            cyc();
            if (changed) chg++;
        end
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (12) begin
            cyc();
            if (changed) chg++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; edit_en = 1'b0;
        btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (3) cyc();
        checks++;
        if (banner !== 40'h0987654321) begin
            errors++; $display("FAIL reset_banner got=%h exp=%h", banner, 40'h0987654321);
        end
        checks++;
        if (cursor !== 4'd0) begin
            errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor);
        end
        checks++;
        if (blank_mask !== 10'd0 || changed !== 1'b0) begin
            errors++; $display("FAIL reset_mask_changed got=%b/%b exp=0/0", blank_mask, changed);
        end
        rst = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_latency();
        int chg;
        edit_en = 1'b1;
        repeat (2) cyc();
        btn_inc = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            checks++;
            if (changed !== (k == 7)) begin
                errors++; $display("FAIL latency_changed edge=%0d got=%b exp=%b", k, changed, (k == 7));
            end
            if (k == 6) begin
                checks++;
                if (banner !== 40'h0987654321) begin
                    errors++; $display("FAIL latency_early got=%h exp=%h", banner, 40'h0987654321);
                end
            end
        end
        checks++;
        if (banner !== 40'h0987654322) begin
            errors++; $display("FAIL latency_banner got=%h exp=%h", banner, 40'h0987654322);
        end
        chg = 0;
        repeat (50) begin
            cyc();
            if (changed) chg++;
        end
        checks++;
        if (banner !== 40'h0987654322 || chg !== 0) begin
            errors++; $display("FAIL held_no_repeat got=%h chg=%0d exp=%h chg=0", banner, chg, 40'h0987654322);
        end
        btn_inc = 1'b0;
        repeat (12) cyc();
    endtask

    task automatic test_glitch();
        int chg;
        chg = 0;
        for (int r = 0; r < 10; r++) begin
            btn_inc = 1'b1;
            repeat (3) begin cyc(); if (changed) chg++; end
            btn_inc = 1'b0;
            repeat (7) begin cyc(); if (changed) chg++; end
        end
        checks++;
        if (banner !== 40'h0987654322 || chg !== 0) begin
            errors++; $display("FAIL glitch got=%h chg=%0d exp=%h chg=0", banner, chg, 40'h0987654322);
        end
    endtask

    task automatic test_wrap();
        int chg;
        int tot;
        tot = 0;
        for (int k = 0; k < 9; k++) begin
            press(1'b1, 1'b0, 1'b0, chg);
            tot += chg;
        end
        checks++;
        if (cursor !== 4'd9 || tot !== 0) begin
            errors++; $display("FAIL cursor_to_9 got=%0d chg=%0d exp=9 chg=0", cursor, tot);
        end
        press(1'b0, 1'b0, 1'b1, chg);
        checks++;
        if (banner !== 40'h9987654322 || chg !== 1) begin
            errors++; $display("FAIL dec_wrap got=%h chg=%0d exp=%h chg=1", banner, chg, 40'h9987654322);
        end
        press(1'b1, 1'b0, 1'b0, chg);
        checks++;
        if (cursor !== 4'd0 || chg !== 0) begin
            errors++; $display("FAIL next_wrap got=%0d chg=%0d exp=0 chg=0", cursor, chg);
        end
    endtask

    task automatic test_simultaneous();
        int chg;
        press(1'b0, 1'b1, 1'b1, chg);
        checks++;
        if (banner !== 40'h9987654322 || chg !== 0) begin
            errors++; $display("FAIL inc_dec_cancel got=%h chg=%0d exp=%h chg=0", banner, chg, 40'h9987654322);
        end
        press(1'b1, 1'b0, 1'b0, chg);
        press(1'b1, 1'b0, 1'b0, chg);
        press(1'b1, 1'b1, 1'b0, chg);
        checks++;
        if (banner !== 40'h9987654422 || cursor !== 4'd3 || chg !== 1) begin
            errors++; $display("FAIL next_inc got=%h cur=%0d chg=%0d exp=%h cur=3 chg=1",
                               banner, cursor, chg, 40'h9987654422);
        end
    endtask

    task automatic test_back_to_back();
        int chg;
        int tot;
        press(1'b0, 1'b1, 1'b0, chg);
        tot = chg;
        press(1'b0, 1'b1, 1'b0, chg);
        tot += chg;
        checks++;
        if (banner !== 40'h9987656422 || tot !== 2) begin
            errors++; $display("FAIL back_to_back got=%h chg=%0d exp=%h chg=2", banner, tot, 40'h9987656422);
        end
    endtask

    task automatic test_disable();
        int chg;
        int tot;
        int mask_hits;
        edit_en = 1'b0;
        tot = 0;
        press(1'b1, 1'b0, 1'b0, chg); tot += chg;
        press(1'b0, 1'b1, 1'b0, chg); tot += chg;
        mask_hits = (blank_mask != 10'd0) ? 1 : 0;
        press(1'b0, 1'b0, 1'b1, chg); tot += chg;
        checks++;
        if (banner !== 40'h9987656422 || cursor !== 4'd3 || tot !== 0) begin
            errors++; $display("FAIL disabled_frozen got=%h cur=%0d chg=%0d exp=%h cur=3 chg=0",
                               banner, cursor, tot, 40'h9987656422);
        end
        checks++;
        if (blank_mask !== 10'd0 || mask_hits !== 0) begin
            errors++; $display("FAIL disabled_mask got=%b hits=%0d exp=0", blank_mask, mask_hits);
        end
    endtask

    task automatic test_blink();
        logic [9:0] exp_mask;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        edit_en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            exp_mask = (((k / 8) % 2) == 1) ? 10'b0000000001 : 10'd0;
            checks++;
            if (blank_mask !== exp_mask) begin
                errors++; $display("FAIL blink edge=%0d got=%b exp=%b", k, blank_mask, exp_mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        int chg;
        edit_en = 1'b1;
        btn_inc = 1'b1;
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chg = 0;
        repeat (20) begin cyc(); if (changed) chg++; end
        checks++;
        if (banner !== 40'h0987654321 || chg !== 0) begin
            errors++; $display("FAIL reset_mid_held got=%h chg=%0d exp=%h chg=0", banner, chg, 40'h0987654321);
        end
        btn_inc = 1'b0;
        repeat (12) begin cyc(); if (changed) chg++; end
        checks++;
        if (banner !== 40'h0987654321 || chg !== 0) begin
            errors++; $display("FAIL reset_mid_release got=%h chg=%0d exp=%h chg=0", banner, chg, 40'h0987654321);
        end
        press(1'b0, 1'b1, 1'b0, chg);
        checks++;
        if (banner !== 40'h0987654322 || chg !== 1) begin
            errors++; $display("FAIL reset_mid_repress got=%h chg=%0d exp=%h chg=1", banner, chg, 40'h0987654322);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_glitch();
        test_wrap();
        test_simultaneous();
        test_back_to_back();
        test_disable();
        test_blink();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
